// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared types and PIO register-map constants for the PIO bus master
package pio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        wnr;
    logic [11:0] address;
    logic [31:0] data;
  } cmd_t;

  localparam logic [11:0] PIO_CTRL      = 12'h000;
  localparam logic [11:0] PIO_IMEM_BASE = 12'h048;
  localparam logic [11:0] PIO_IMEM_LAST = 12'h0C4;

  localparam logic [11:0] SM0_CLKDIV    = 12'h0C8;
  localparam logic [11:0] SM0_EXECCTRL  = 12'h0CC;
  localparam logic [11:0] SM0_SHIFTCTRL = 12'h0D0;
  localparam logic [11:0] SM0_PINCTRL   = 12'h0DC;
  localparam logic [11:0] SM_STRIDE     = 12'h018;

  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  // Address of a per-SM register given its SM0 address.
  function automatic logic [11:0] sm_reg(input logic [1:0] sm, input logic [11:0] sm0_addr);
    return sm0_addr + 12'(sm) * SM_STRIDE;
  endfunction

endpackage

// File: rtl/pio_cmd_fifo.sv
// rtl/pio_cmd_fifo.sv - synchronous command FIFO with registered ready (not full)
module pio_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  // ready is computed from the next occupancy so it never depends on the current pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pio_bus_master.sv
// rtl/pio_bus_master.sv - queued PIO bus initiator with ack timeout and alignment checking
module pio_bus_master
  import pio_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_writeNotRead,
  input  logic [11:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        out_strobe,
  output logic        out_writeNotRead,
  output logic [11:0] out_address,
  output logic [31:0] out_data,
  input  logic [31:0] in_data,
  input  logic        in_ack,
  output logic        out_busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  cmd_t          head;
  cmd_t          txn;
  logic          have_txn;
  logic          empty;
  logic          pop;
  logic [TW-1:0] tcount;
  logic [TW-1:0] tcount_inc;

  pio_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_writeNotRead, cmd_address, cmd_data}),
    .ready     (cmd_ready),
    .pop       (pop),
    .head      (head),
    .empty     (empty)
  );

  assign pop        = (state == ST_IDLE) & ~have_txn & ~empty;
  assign tcount_inc = tcount + 1'b1;
  assign out_busy   = ~empty | have_txn | (state != ST_IDLE);

  // IDLE spends one cycle loading the transaction register, then one deciding; this keeps strobe low >= 2 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      txn              <= '0;
      have_txn         <= 1'b0;
      tcount           <= '0;
      out_strobe       <= 1'b0;
      out_writeNotRead <= 1'b0;
      out_address      <= '0;
      out_data         <= '0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (have_txn) begin
            have_txn <= 1'b0;
            if (txn.address[1:0] != 2'b00) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_data  <= ERR_DATA;
              resp_error <= 1'b1;
            end else begin
              state            <= ST_BUS;
              out_strobe       <= 1'b1;
              out_address      <= txn.address;
              out_data         <= txn.data;
              out_writeNotRead <= txn.wnr;
            end
          end else if (pop) begin
            txn      <= head;
            have_txn <= 1'b1;
          end
        end
        ST_BUS: begin
          if (in_ack) begin
            state      <= ST_RESP;
            out_strobe <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= out_writeNotRead ? '0 : in_data;
            resp_error <= 1'b0;
          end else if (tcount_inc == TW'(TIMEOUT_CYCLES)) begin
            state      <= ST_RESP;
            out_strobe <= 1'b0;
            tcount     <= tcount_inc;
            resp_valid <= 1'b1;
            resp_data  <= ERR_DATA;
            resp_error <= 1'b1;
          end else begin
            tcount <= tcount_inc;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            tcount     <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_bus_master.sv
// tb/tb_pio_bus_master.sv - self-checking bench for pio_bus_master with a behavioural PIO slave
module tb_pio_bus_master;
  import pio_pkg::*;

  localparam int NEVER = 1 << 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_writeNotRead = 1'b0;
  logic [11:0] cmd_address = '0;
  logic [31:0] cmd_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        out_strobe;
  logic        out_writeNotRead;
  logic [11:0] out_address;
  logic [31:0] out_data;
  logic [31:0] in_data;
  logic        in_ack;
  logic        out_busy;

  always #5 clk = ~clk;

  pio_bus_master dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_writeNotRead (cmd_writeNotRead),
    .cmd_address      (cmd_address),
    .cmd_data         (cmd_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_error       (resp_error),
    .out_strobe       (out_strobe),
    .out_writeNotRead (out_writeNotRead),
    .out_address      (out_address),
    .out_data         (out_data),
    .in_data          (in_data),
    .in_ack           (in_ack),
    .out_busy         (out_busy)
  );

  // Slave: word registers, EXECCTRL resets to 0x0001F000, ack after ack_wait strobe cycles
  logic [31:0] regs [1024];
  logic [11:0] exec_addr;
  int          cur_hi;
  int          ack_wait = 0;

  assign in_ack  = out_strobe && (cur_hi >= ack_wait);
  assign in_data = regs[out_address[11:2]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) regs[i] <= 32'h0;
      for (int s = 0; s < 4; s++) begin
        exec_addr = sm_reg(2'(s), SM0_EXECCTRL);
        regs[exec_addr[11:2]] <= 32'h0001_F000;
      end
      cur_hi <= 0;
    end else begin
      cur_hi <= out_strobe ? cur_hi + 1 : 0;
      if (out_strobe && in_ack && out_writeNotRead) regs[out_address[11:2]] <= out_data;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic        e;
  } resp_t;

  typedef struct {
    logic        wnr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic        exp_e;
    int          strobes;
  } vec_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    nresp = 0;
  int    strobe_cycles = 0;
  int    lo_run = 100;
  logic  prev_strobe = 1'b0;
  logic [11:0] prev_addr = '0;
  logic  prev_rv = 1'b0;
  logic  prev_rr = 1'b0;
  logic [31:0] prev_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard and bus-protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual=%h required=none", resp_data);
        end else begin
          resp_t r;
          r = sb.pop_front();
          nresp++;
          chk("resp_data", resp_data, r.d);
          chk("resp_error", 32'(resp_error), 32'(r.e));
        end
      end
      if (resp_valid && prev_rv && !prev_rr) chk("resp_stable", resp_data, prev_rd);
      if (out_strobe) begin
        strobe_cycles++;
        if (!prev_strobe) chk("strobe_gap_ge2", 32'(lo_run >= 2), 32'd1);
        else              chk("addr_stable", 32'(out_address), 32'(prev_addr));
      end
      lo_run      = out_strobe ? 0 : lo_run + 1;
      prev_strobe = out_strobe;
      prev_addr   = out_address;
      prev_rv     = resp_valid;
      prev_rr     = resp_ready;
      prev_rd     = resp_data;
    end
  end

  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee, input int budget, output bit acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_writeNotRead = w;
    cmd_address = a;
    cmd_data = d;
    acc = 1'b0;
    for (int k = 0; k < budget && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        sb.push_back('{d: ed, e: ee});
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_busy && !resp_valid) done = 1'b1;
    end
    chk("drain_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    bit   acc;
    int   base;
    logic [11:0] bp_addr [5];
    logic [31:0] bp_exp [5];

    vecs[0] = '{1'b1, PIO_CTRL,      32'h0000_000F, 32'h0,          1'b0, 1};
    vecs[1] = '{1'b0, PIO_CTRL,      32'h0,         32'h0000_000F,  1'b0, 1};
    vecs[2] = '{1'b1, PIO_IMEM_BASE, 32'h0000_A0C1, 32'h0,          1'b0, 1};
    vecs[3] = '{1'b0, PIO_IMEM_BASE, 32'h0,         32'h0000_A0C1,  1'b0, 1};
    vecs[4] = '{1'b0, 12'h0CC,       32'h0,         32'h0001_F000,  1'b0, 1};
    vecs[5] = '{1'b0, 12'h0C9,       32'h0,         32'h0,          1'b1, 0};
    vecs[6] = '{1'b1, PIO_IMEM_LAST, 32'h1234_5678, 32'h0,          1'b0, 1};
    vecs[7] = '{1'b0, PIO_IMEM_LAST, 32'h0,         32'h1234_5678,  1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_out_strobe", 32'(out_strobe), 32'd0);
    chk("rst_out_busy", 32'(out_busy), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    foreach (vecs[i]) begin
      strobe_cycles = 0;
      send(vecs[i].wnr, vecs[i].addr, vecs[i].data, vecs[i].exp_d, vecs[i].exp_e, 30, acc);
      chk("vec_accept", 32'(acc), 32'd1);
      drain(200);
      chk("vec_strobe_len", 32'(strobe_cycles), 32'(vecs[i].strobes));
    end

    // Latency: aligned read accepted at edge N -> strobe in N+2, resp_valid in N+3
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_writeNotRead = 1'b0; cmd_address = PIO_CTRL;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sb.push_back('{d: 32'h0000_000F, e: 1'b0});
    @(posedge clk); #1;
    chk("lat_strobe_n1", 32'(out_strobe), 32'd0);
    @(posedge clk); #1;
    chk("lat_strobe_n2", 32'(out_strobe), 32'd1);
    @(posedge clk); #1;
    chk("lat_resp_n3", 32'(resp_valid), 32'd1);
    chk("lat_strobe_n3", 32'(out_strobe), 32'd0);
    drain(50);

    // Misaligned: no strobe, error response in N+2
    strobe_cycles = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_writeNotRead = 1'b0; cmd_address = 12'h0C9;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sb.push_back('{d: 32'h0, e: 1'b1});
    @(posedge clk); #1;
    chk("mis_resp_n1", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("mis_resp_n2", 32'(resp_valid), 32'd1);
    drain(50);
    chk("mis_no_strobe", 32'(strobe_cycles), 32'd0);

    // Timeout, recovery, and ack arriving on the last allowed cycle
    ack_wait = NEVER;
    strobe_cycles = 0;
    send(1'b0, SM0_CLKDIV, 32'h0, 32'h0, 1'b1, 30, acc);
    drain(200);
    chk("timeout_strobe_len", 32'(strobe_cycles), 32'd16);
    ack_wait = 0;
    strobe_cycles = 0;
    send(1'b0, SM0_EXECCTRL, 32'h0, 32'h0001_F000, 1'b0, 30, acc);
    drain(200);
    chk("recover_strobe_len", 32'(strobe_cycles), 32'd1);
    ack_wait = 15;
    strobe_cycles = 0;
    send(1'b0, PIO_IMEM_BASE, 32'h0, 32'h0000_A0C1, 1'b0, 30, acc);
    drain(200);
    chk("ack_wins_strobe_len", 32'(strobe_cycles), 32'd16);
    ack_wait = 0;

    // Backpressure: 1 in flight + 4 queued, sixth refused, then drained in order
    bp_addr = '{12'h0CC, 12'h048, 12'h000, 12'h0C4, 12'h0FC};
    bp_exp  = '{32'h0001_F000, 32'h0000_A0C1, 32'h0000_000F, 32'h1234_5678, 32'h0001_F000};
    resp_ready = 1'b0;
    base = nresp;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, bp_addr[i], 32'h0, bp_exp[i], 1'b0, 30, acc);
      chk("bp_accept", 32'(acc), 32'd1);
    end
    send(1'b0, 12'h0C9, 32'h0, 32'h0, 1'b1, 20, acc);
    chk("bp_sixth_refused", 32'(acc), 32'd0);
    chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(out_busy), 32'd1);
    chk("bp_held_resp", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    drain(300);
    chk("bp_resp_count", 32'(nresp - base), 32'd5);
    chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // Reset during BUS drops the command
    ack_wait = NEVER;
    send(1'b0, PIO_CTRL, 32'h0, 32'h0000_000F, 1'b0, 30, acc);
    for (int k = 0; k < 10 && !out_strobe; k++) @(negedge clk);
    chk("rst_mid_in_bus", 32'(out_strobe), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_strobe", 32'(out_strobe), 32'd0);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    sb.delete();
    base = nresp;
    @(negedge clk);
    reset = 1'b0;
    ack_wait = 0;
    repeat (3) @(negedge clk);
    chk("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rel_busy", 32'(out_busy), 32'd0);
    chk("rst_no_resp", 32'(nresp - base), 32'd0);
    send(1'b0, PIO_CTRL, 32'h0, 32'h0, 1'b0, 30, acc);
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_bus_master.md
Name: pio_bus_master

Overview:
Bus initiator for the PIO register/instruction-memory slave interface (strobe, writeNotRead, 12-bit address, 32-bit data, ack). It accepts queued register commands from a host-side logic port and issues them one at a time on the PIO bus. It returns read data or write completion on a response port, flagging ack timeouts and misaligned addresses. It sits between the host control logic (IPbus endpoint or test sequencer) and the pio top level.

Parameters:
CMD_DEPTH, 4, command queue depth; power of two, at least 2.
TIMEOUT_CYCLES, 16, strobe-high cycles without ack before the transaction is aborted; at least 1.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept a command (not full)
cmd_writeNotRead  in  1  1 = write, 0 = read
cmd_address  in  12  PIO byte address
cmd_data  in  32  write data (ignored for reads)
resp_valid  out  1  response available
resp_ready  in  1  response consumed
resp_data  out  32  read data; 0 for writes and errors
resp_error  out  1  1 = timeout or misaligned address
out_strobe  out  1  bus strobe to PIO
out_writeNotRead  out  1  bus direction
out_address  out  12  bus address
out_data  out  32  bus write data
in_data  in  32  bus read data from PIO
in_ack  in  1  bus acknowledge from PIO (may be combinational from out_strobe)
out_busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset (async, takes effect immediately):
  - All outputs are 0; cmd_ready is 1 once reset is released.
  - Queue is emptied, FSM goes to IDLE, timeout counter is 0.
  - Reset mid-transaction drops the command; no response is produced.
- Queue:
  - FIFO of {writeNotRead, address, data}, CMD_DEPTH entries.
  - Push on cmd_valid & cmd_ready; cmd_ready = !full, registered, with no combinational path from a pop.
  - A push while full is impossible by construction.
  - Simultaneous push and pop when not full is allowed; occupancy is unchanged.
- FSM states: IDLE, BUS, RESP. All bus outputs are registered.
- IDLE:
  - If the queue is non-empty, pop the head into the transaction register.
  - If address[1:0] != 0, go to RESP with resp_error=1, resp_data=0, and no bus access.
  - Otherwise go to BUS and load out_address, out_data and out_writeNotRead.
- BUS:
  - out_strobe=1 with stable address, data and direction.
  - in_ack is sampled each cycle. On ack, capture in_data (reads) or 0 (writes) into resp_data, set resp_error=0, go to RESP. A write takes exactly one strobe cycle when ack is immediate.
  - The timeout counter increments on each strobe cycle without ack. When the count reaches TIMEOUT_CYCLES, go to RESP with resp_error=1, resp_data=0.
  - If ack arrives in the same cycle the count would expire, ack wins.
- RESP:
  - out_strobe=0; resp_valid=1 with resp_data and resp_error held stable until resp_ready.
  - On resp_valid & resp_ready go to IDLE and clear the counter.
- Strobe timing:
  - out_strobe is low for at least 2 cycles between transactions (RESP and IDLE).
  - The slave never sees back-to-back strobes.
- Latency: command accepted at edge N gives out_strobe high in cycle N+2 and resp_valid in cycle N+3 (empty queue, immediate ack, resp_ready held 1).
- Ordering: responses are strictly in command order, one per command.
- out_address and out_data hold their last values after a transaction; only out_strobe qualifies them.

Decomposition:
- Shared package pio_pkg holds:
  - FSM state encoding.
  - PIO register-map constants: CTRL 12'h000, IMEM_BASE 12'h048, IMEM_LAST 12'h0C4.
  - Per-SM CLKDIV/EXECCTRL/SHIFTCTRL/PINCTRL addresses (SM0 0x0C8/0x0CC/0x0D0/0x0DC, stride 0x18).
  - Error read-data value 0.
- One sub-module: pio_cmd_fifo, a parameterised synchronous FIFO with full/empty flags and the same async active-high reset.

Test Plan:
1. Bench wired to pio. Write CTRL 12'h000 = 32'h0000000F, then read 12'h000 -> write response resp_data=0, resp_error=0; read response resp_data=32'h0000000F; strobe high exactly 1 cycle each.
2. Write 12'h048 = 32'h0000A0C1, then read 12'h048 -> resp_data=32'h0000A0C1. Read 12'h0CC after reset -> resp_data=32'h0001F000.
3. in_ack tied 0, read 12'h0C8 -> out_strobe high 16 cycles, then resp_valid with resp_error=1, resp_data=0; next command proceeds normally.
4. Command at address 12'h0C9 -> out_strobe never asserts; resp_error=1 two cycles after the pop.
5. resp_ready held 0 and 6 commands offered -> 4 queued plus 1 in flight, then cmd_ready=0. Release resp_ready -> 5 responses in issue order, cmd_ready returns to 1.
6. Assert reset during BUS -> out_strobe=0 in the same cycle, no response. After release, cmd_ready=1, out_busy=0, and a subsequent read of 12'h000 returns 0.
